bcd_score_display: RTL

//  Downstream stage of the binary-to-BCD converter: captures the converter's packed BCD word on a

---
 rtl/bcd_score_display.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/bcd_score_display.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : bcd_score_display                                               |
// | Captures a packed BCD score and drives six active-low 7-segment displays.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bcd_score_display #(
    parameter int W            = 19,
    parameter int NDIG         = 6,
    parameter int BLINK_CYCLES = 25_000_000,
    parameter int BLINK_COUNT  = 3,
    localparam int BW          = W + (W - 4) / 3 + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [BW-1:0] bcd_in,
    input  logic          load,
    input  logic          blank_lz,
    input  logic          blink_en,
    output logic [6:0]    hex0,
    output logic [6:0]    hex1,
    output logic [6:0]    hex2,
    output logic [6:0]    hex3,
    output logic [6:0]    hex4,
    output logic [6:0]    hex5,
    output logic          busy
);

    localparam int DW = NDIG * 4;
    localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int RW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

    localparam logic [CW-1:0] c_cnt_last  = CW'(BLINK_CYCLES - 1);
    localparam logic [RW-1:0] c_rep_last  = RW'(BLINK_COUNT - 1);
    localparam logic [6:0]    c_seg_off   = 7'h7F;
    localparam logic [6:0]    c_seg_dash  = 7'h3F;

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_blink_off = 2'd1;
    localparam logic [1:0] c_blink_on  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [RW-1:0]         r_rep;
    logic [RW-1:0]         w_rep_nxt;
    logic [DW-1:0]         r_digits;
    logic [DW-1:0]         w_load_val;
    logic                  r_shown;
    logic                  r_busy;
    logic [NDIG-1:0][6:0]  w_segs;
    logic [5:0][6:0]       w_disp;
    logic [5:0][6:0]       w_hex;
    logic [5:0][6:0]       r_hex;
    logic                  w_seen;
    logic [3:0]            w_d;

    // Fit the converter word to the digit register (truncate or zero-extend).
    generate
        if (BW > DW) begin : g_trunc
            logic w_unused_bcd;
            assign w_load_val   = bcd_in[DW-1:0];
            assign w_unused_bcd = ^bcd_in[BW-1:DW];
        end else if (BW == DW) begin : g_exact
            assign w_load_val = bcd_in;
        end else begin : g_zext
            assign w_load_val = {{(DW - BW){1'b0}}, bcd_in};
        end
    endgenerate

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = c_seg_dash;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_rep   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rep   <= w_rep_nxt;
        end
    end

    // A load always wins over the phase counter, restarting or cancelling the blink.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rep_nxt   = r_rep;
        if (load) begin
            w_state_nxt = blink_en ? c_blink_off : c_idle;
            w_cnt_nxt   = '0;
            w_rep_nxt   = '0;
        end else begin
            case (r_state)
                c_blink_off: begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = c_blink_on;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                c_blink_on: begin
                    if (r_cnt == c_cnt_last) begin
                        w_cnt_nxt = '0;
                        if (r_rep == c_rep_last) begin
                            w_state_nxt = c_idle;
                            w_rep_nxt   = '0;
                        end else begin
                            w_state_nxt = c_blink_off;
                            w_rep_nxt   = r_rep + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_idle;
                    w_cnt_nxt   = '0;
                    w_rep_nxt   = '0;
                end
            endcase
        end
    end

    // Walk from the top digit down; zeros are blanked until the first nonzero code.
    always_comb begin
        w_seen = 1'b0;
        w_d    = '0;
        w_segs = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            w_d = r_digits[i*4 +: 4];
            if (blank_lz && !w_seen && (i != 0) && (w_d == 4'd0)) begin
                w_segs[i] = c_seg_off;
            end else begin
                w_segs[i] = f_seg(w_d);
            end
            if (w_d != 4'd0) begin
                w_seen = 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < 6; g++) begin : g_hex
            if (g < NDIG) begin : g_used
                assign w_disp[g] = w_segs[g];
            end else begin : g_unused
                assign w_disp[g] = c_seg_off;
            end
        end
    endgenerate

    always_comb begin
        w_hex = {6{c_seg_off}};
        if (r_shown && (r_state != c_blink_off)) begin
            w_hex = w_disp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= '0;
            r_shown  <= 1'b0;
            r_hex    <= {6{c_seg_off}};
            r_busy   <= 1'b0;
        end else begin
            if (load) begin
                r_digits <= w_load_val;
                r_shown  <= 1'b1;
            end
            r_hex  <= w_hex;
            r_busy <= (r_state != c_idle);
        end
    end

    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];
    assign busy = r_busy;

endmodule
`default_nettype wire
